// File: rtl/bit_destuffer_pkg.sv
// Shared definitions for the CAN bit destuffer: default parameters and state encodings.
// The error-frame logic decodes ERROR, so these encodings must stay fixed.
package bit_destuffer_pkg;

  localparam int DEFAULT_STUFF_LEN = 5;
  localparam int DEFAULT_COUNT_W   = 8;
  localparam int RUN_W             = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } destuff_state_t;

endpackage

// File: rtl/bit_destuffer_if.sv
// Bus between the bit-timing/frame-decoder side (master) and the destuffer (slave).
interface bit_destuffer_if
  import bit_destuffer_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W
);

  logic               sp;
  logic               CAN_RX;
  logic               stuffEnable;
  logic               isStuff;
  logic               stuffError;
  logic               stuffErrPulse;
  logic [COUNT_W-1:0] stuffCount;
  logic [RUN_W-1:0]   runLength;

  modport master (
    output sp, CAN_RX, stuffEnable,
    input  isStuff, stuffError, stuffErrPulse, stuffCount, runLength
  );

  modport slave (
    input  sp, CAN_RX, stuffEnable,
    output isStuff, stuffError, stuffErrPulse, stuffCount, runLength
  );

endinterface

// File: rtl/bit_destuffer.sv
// Flags CAN stuff bits at each sample point so frameStorage can drop them,
// and detects stuff errors (a sixth equal bit where a stuff bit was due).
module bit_destuffer
  import bit_destuffer_pkg::*;
#(
  parameter int STUFF_LEN = DEFAULT_STUFF_LEN,
  parameter int COUNT_W   = DEFAULT_COUNT_W
) (
  input  logic           clock,
  input  logic           reset,
  bit_destuffer_if.slave bus
);

  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(STUFF_LEN);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  destuff_state_t     state;
  logic [RUN_W-1:0]   run_length;
  logic               last_bit;
  logic [COUNT_W-1:0] stuff_count;
  logic               err_pulse;

  // Dropping stuffEnable on any sample point wins over everything else, so a
  // stuff position coinciding with the end of the CRC never raises an error.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      run_length  <= '0;
      last_bit    <= 1'b1;
      stuff_count <= '0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.sp) begin
        if (!bus.stuffEnable) begin
          state       <= IDLE;
          run_length  <= '0;
          stuff_count <= '0;
        end else begin
          case (state)
            IDLE: begin
              state      <= ACTIVE;
              last_bit   <= bus.CAN_RX;
              run_length <= RUN_W'(1);
            end
            ACTIVE: begin
              if (run_length == RUN_MAX) begin
                if (bus.CAN_RX != last_bit) begin
                  // The stuff bit itself opens the next run of equal bits.
                  last_bit   <= bus.CAN_RX;
                  run_length <= RUN_W'(1);
                  if (stuff_count != COUNT_MAX) begin
                    stuff_count <= stuff_count + COUNT_W'(1);
                  end
                end else begin
                  state      <= ERROR;
                  err_pulse  <= 1'b1;
                  run_length <= '0;
                end
              end else if (bus.CAN_RX == last_bit) begin
                run_length <= run_length + RUN_W'(1);
              end else begin
                last_bit   <= bus.CAN_RX;
                run_length <= RUN_W'(1);
              end
            end
            ERROR: begin
              state <= ERROR;
            end
            default: begin
              state      <= IDLE;
              run_length <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.isStuff       = (state == ACTIVE) && bus.stuffEnable && (run_length == RUN_MAX);
  assign bus.stuffError    = (state == ERROR);
  assign bus.stuffErrPulse = err_pulse;
  assign bus.stuffCount    = stuff_count;
  assign bus.runLength     = run_length;

endmodule
